serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder, one full adder reused LSB first over WIDTH cycles
// The A register doubles as the result shift register: sum bits enter at the MSB as A bits leave at the LSB.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
  logic             last_bit;
  logic [WIDTH-1:0] a_shift;

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  if (WIDTH == 1) begin : g_one
    assign a_shift = fa_s;
  end else begin : g_multi
    assign a_shift = {fa_s, a_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_shift;
        b_d     = b_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        // The final bit is folded in on the completion edge itself.
        if (last_bit) begin
          sum_d  = a_shift;
          cout_d = fa_co;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl at WIDTH 8, 4 and 1

module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       rst4, start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
  logic       rst1, start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );
  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );
  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    int          w;
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic [63:0] s;
    logic        co;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int w, input logic s, input logic [63:0] a, input logic [63:0] b, input logic ci);
    case (w)
      8: begin start8 = s; a8 = a[7:0]; b8 = b[7:0]; cin8 = ci; end
      4: begin start4 = s; a4 = a[3:0]; b4 = b[3:0]; cin4 = ci; end
      default: begin start1 = s; a1 = a[0:0]; b1 = b[0:0]; cin1 = ci; end
    endcase
  endtask

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : (w == 4) ? busy4 : busy1;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : (w == 4) ? done4 : done1;
  endfunction
  function automatic logic [63:0] get_sum(input int w);
    return (w == 8) ? 64'(sum8) : (w == 4) ? 64'(sum4) : 64'(sum1);
  endfunction
  function automatic logic get_cout(input int w);
    return (w == 8) ? cout8 : (w == 4) ? cout4 : cout1;
  endfunction

  function automatic logic [64:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b, input logic ci);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    return {1'b0, a & mask} + {1'b0, b & mask} + 65'(ci);
  endfunction

  // One operation: start pulse, scrambled inputs after capture, then latency/busy/hold/result checks.
  task automatic op(input int w, input logic [63:0] a, input logic [63:0] b, input logic ci,
                    input logic [63:0] exp_s, input logic exp_co);
    logic [63:0] prev_sum;
    logic        prev_co;
    int          n, busy_n;
    logic        hold_ok;
    @(negedge clk);
    prev_sum = get_sum(w);
    prev_co  = get_cout(w);
    set_in(w, 1'b1, a, b, ci);
    @(negedge clk);
    set_in(w, 1'b0, 64'($urandom), 64'($urandom), 1'($urandom));
    n = 0; busy_n = 0; hold_ok = 1'b1;
    while (!get_done(w) && n < 100) begin
      if (get_busy(w)) busy_n++;
      if (get_sum(w) !== prev_sum || get_cout(w) !== prev_co) hold_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    check($sformatf("latency w%0d", w), 64'(n), 64'(w));
    check($sformatf("busy_cycles w%0d", w), 64'(busy_n), 64'(w));
    check($sformatf("hold w%0d", w), 64'(hold_ok), 64'd1);
    check($sformatf("sum w%0d %0h+%0h+%0h", w, a, b, ci), get_sum(w), exp_s);
    check($sformatf("cout w%0d %0h+%0h+%0h", w, a, b, ci), 64'(get_cout(w)), 64'(exp_co));
    check($sformatf("busy_at_done w%0d", w), 64'(get_busy(w)), 64'd0);
    @(negedge clk);
    check($sformatf("done_single w%0d", w), 64'(get_done(w)), 64'd0);
  endtask

  task automatic rand_op(input int w, input logic [63:0] a, input logic [63:0] b, input logic ci);
    logic [64:0] full;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    full = ref_add(w, a, b, ci);
    op(w, a, b, ci, full[63:0] & mask, full[w]);
  endtask

  initial begin
    int done_n, busy_n;
    logic [63:0] got;

    vecs[0] = '{8, 64'hFF, 64'h01, 1'b0, 64'h00, 1'b1};
    vecs[1] = '{8, 64'h00, 64'h00, 1'b1, 64'h01, 1'b0};
    vecs[2] = '{8, 64'hA5, 64'h5A, 1'b1, 64'h00, 1'b1};
    vecs[3] = '{8, 64'h80, 64'h80, 1'b0, 64'h00, 1'b1};
    vecs[4] = '{8, 64'h7F, 64'h00, 1'b1, 64'h80, 1'b0};
    vecs[5] = '{4, 64'hF, 64'hF, 1'b1, 64'hF, 1'b1};
    vecs[6] = '{1, 64'h1, 64'h1, 1'b1, 64'h1, 1'b1};
    vecs[7] = '{1, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
    vecs[8] = '{1, 64'h1, 64'h0, 1'b1, 64'h0, 1'b1};

    // Reset held with start asserted: reset must win.
    rst8 = 1'b0; rst4 = 1'b0; rst1 = 1'b0;
    set_in(8, 1'b1, 64'h12, 64'h34, 1'b1);
    set_in(4, 1'b1, 64'h5, 64'h6, 1'b1);
    set_in(1, 1'b1, 64'h1, 64'h1, 1'b1);
    repeat (3) @(negedge clk);
    for (int w = 1; w <= 8; w++) begin
      if (w == 1 || w == 4 || w == 8) begin
        check($sformatf("rst busy w%0d", w), 64'(get_busy(w)), 64'd0);
        check($sformatf("rst done w%0d", w), 64'(get_done(w)), 64'd0);
        check($sformatf("rst sum w%0d", w), get_sum(w), 64'd0);
        check($sformatf("rst cout w%0d", w), 64'(get_cout(w)), 64'd0);
      end
    end
    set_in(8, 1'b0, 0, 0, 1'b0);
    set_in(4, 1'b0, 0, 0, 1'b0);
    set_in(1, 1'b0, 0, 0, 1'b0);
    rst8 = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
    check("idle_no_start busy", 64'(busy8), 64'd0);

    for (int i = 0; i < 9; i++)
      op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);

    // Second start 3 cycles into RUN must be ignored.
    @(negedge clk);
    set_in(8, 1'b1, 64'h03, 64'h04, 1'b0);
    done_n = 0; busy_n = 0; got = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      set_in(8, (i == 2), (i == 2) ? 64'hFF : 64'h0, 64'h0, 1'b0);
      if (busy8) busy_n++;
      if (done8) begin done_n++; got = 64'(sum8); end
    end
    check("ignore_start done_count", 64'(done_n), 64'd1);
    check("ignore_start busy_cycles", 64'(busy_n), 64'd8);
    check("ignore_start sum", got, 64'h07);
    check("ignore_start final_sum", 64'(sum8), 64'h07);

    // Reset 4 cycles into RUN aborts with no done.
    @(negedge clk);
    set_in(8, 1'b1, 64'h10, 64'h20, 1'b0);
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_in(8, 1'b0, 64'h0, 64'h0, 1'b0);
      if (done8) done_n++;
    end
    rst8 = 1'b0;
    @(negedge clk);
    check("abort busy", 64'(busy8), 64'd0);
    check("abort done", 64'(done8), 64'd0);
    check("abort sum", 64'(sum8), 64'd0);
    check("abort cout", 64'(cout8), 64'd0);
    rst8 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) done_n++;
    end
    check("abort no_done", 64'(done_n), 64'd0);
    op(8, 64'h01, 64'h01, 1'b0, 64'h02, 1'b0);

    for (int i = 0; i < 40; i++)
      rand_op(8, 64'($urandom), 64'($urandom), 1'($urandom));
    for (int i = 0; i < 10; i++)
      rand_op(1, 64'($urandom), 64'($urandom), 1'($urandom));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          rand_op(4, 64'(a), 64'(b), c[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
